streaming_fifo_param: RTL and testbench

- Parametrised AXI-Stream FIFO; next generation of the single-channel Q_srl-style stream FIFO.
- Inserted between dataflow layers to absorb rate mismatch.
- Adds the following over the previous block:
  - arbitrary (non-power-of-2) depth;
  - registered, glitch-free handshake outputs;
  - programmable almost-full/almost-empty flags;
  - optional peak-occupancy monitor for FIFO sizing.

---
 rtl/streaming_fifo_param_if.sv | 11 +
 rtl/streaming_fifo_param.sv | 112 +++++++++++
 tb/tb_streaming_fifo_param.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/streaming_fifo_param_if.sv
// AXI-Stream beat channel (TDATA/TVALID/TREADY) shared by the FIFO input and output sides.
interface streaming_fifo_param_if #(
   parameter int unsigned WIDTH = 8
);
   logic [WIDTH-1:0] TDATA;
   logic             TVALID;
   logic             TREADY;

   modport master (output TDATA, output TVALID, input TREADY);
   modport slave  (input TDATA, input TVALID, output TREADY);
endinterface

// File: rtl/streaming_fifo_param.sv
// Parametrised AXI-Stream FIFO: circular RAM of DEPTH-1 beats plus a first-word-fall-through output register.
// Define STREAMING_FIFO_PEAK_EN to add the peak-occupancy monitor (peak_count / peak_clr).
module streaming_fifo_param #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned DEPTH    = 8192,
   parameter int unsigned AF_LEVEL = DEPTH - 2,
   parameter int unsigned AE_LEVEL = 2,
   parameter int unsigned CW       = $clog2(DEPTH + 1)
) (
   input  logic                   ap_clk,
   input  logic                   ap_rst,
   streaming_fifo_param_if.slave  in0_V_V,
   streaming_fifo_param_if.master out_V_V,
   output logic [CW-1:0]          count,
   output logic                   almost_full,
   output logic                   almost_empty
`ifdef STREAMING_FIFO_PEAK_EN
   ,
   output logic [CW-1:0]          peak_count,
   input  logic                   peak_clr
`endif
);

   localparam int unsigned RAM_DEPTH = DEPTH - 1;
   localparam int unsigned PW        = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
   localparam logic [PW-1:0] LAST_PTR = PW'(RAM_DEPTH - 1);

   logic [WIDTH-1:0] ram [RAM_DEPTH];

   logic [PW-1:0]    wr_ptr, rd_ptr, wr_ptr_next, rd_ptr_next;
   logic [CW-1:0]    ram_cnt, ram_cnt_next, count_next;
   logic             out_valid, out_valid_next;
   logic [WIDTH-1:0] out_data;
   logic             in_ready, in_ready_next;
   logic             af_next, ae_next;

   logic push_c, pop_c, out_free_c, ram_rd_c, ram_wr_c, bypass_c;

   // Handshake decode and datapath steering; the RAM feeds the output register
   // whenever it holds data, otherwise an incoming beat bypasses straight into it.
   always_comb begin
      push_c         = in0_V_V.TVALID & in_ready;
      pop_c          = out_valid & out_V_V.TREADY;
      out_free_c     = ~out_valid | pop_c;
      ram_rd_c       = out_free_c & (ram_cnt != '0);
      bypass_c       = out_free_c & (ram_cnt == '0) & push_c;
      ram_wr_c       = push_c & ~bypass_c;
      out_valid_next = out_free_c ? (ram_rd_c | bypass_c) : out_valid;

      wr_ptr_next = wr_ptr;
      if (ram_wr_c) wr_ptr_next = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
      rd_ptr_next = rd_ptr;
      if (ram_rd_c) rd_ptr_next = (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);

      ram_cnt_next  = ram_cnt + CW'(ram_wr_c) - CW'(ram_rd_c);
      count_next    = count + CW'(push_c) - CW'(pop_c);
      in_ready_next = (count_next < CW'(DEPTH));
      af_next       = (count_next >= CW'(AF_LEVEL));
      ae_next       = (count_next <= CW'(AE_LEVEL));
   end

   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         ram_cnt      <= '0;
         count        <= '0;
         out_valid    <= 1'b0;
         out_data     <= '0;
         in_ready     <= 1'b1;
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
      end else begin
         wr_ptr       <= wr_ptr_next;
         rd_ptr       <= rd_ptr_next;
         ram_cnt      <= ram_cnt_next;
         count        <= count_next;
         out_valid    <= out_valid_next;
         in_ready     <= in_ready_next;
         almost_full  <= af_next;
         almost_empty <= ae_next;
         if (ram_rd_c)      out_data <= ram[rd_ptr];
         else if (bypass_c) out_data <= in0_V_V.TDATA;
      end
   end

   // Storage array, no reset so it maps onto a RAM macro.
   always_ff @(posedge ap_clk) begin
      if (ram_wr_c) ram[wr_ptr] <= in0_V_V.TDATA;
   end

   assign in0_V_V.TREADY = in_ready;
   assign out_V_V.TVALID = out_valid;
   assign out_V_V.TDATA  = out_data;

`ifdef STREAMING_FIFO_PEAK_EN
   logic [CW-1:0] peak_next;

   // Clear reloads from the post-update occupancy so the monitor restarts from "now".
   always_comb begin
      peak_next = peak_count;
      if (peak_clr)                     peak_next = count_next;
      else if (count_next > peak_count) peak_next = count_next;
   end

   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) peak_count <= '0;
      else        peak_count <= peak_next;
   end
`endif

endmodule

// File: tb/tb_streaming_fifo_param.sv
// Scoreboard bench for streaming_fifo_param: DEPTH=8 directed scenarios and a DEPTH=5 wrap stream.
module tb_streaming_fifo_param;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   streaming_fifo_param_if #(.WIDTH(8))  in8 ();
   streaming_fifo_param_if #(.WIDTH(8))  out8 ();
   streaming_fifo_param_if #(.WIDTH(16)) in5 ();
   streaming_fifo_param_if #(.WIDTH(16)) out5 ();

   logic [3:0] cnt8;
   logic       af8, ae8;
   logic [2:0] cnt5;
   logic       af5, ae5;
`ifdef STREAMING_FIFO_PEAK_EN
   logic [3:0] peak8;
   logic       clr8 = 1'b0;
   logic [2:0] peak5;
   logic       clr5 = 1'b0;
`endif

   streaming_fifo_param #(.WIDTH(8), .DEPTH(8)) dut8 (
      .ap_clk(clk), .ap_rst(rst), .in0_V_V(in8), .out_V_V(out8),
      .count(cnt8), .almost_full(af8), .almost_empty(ae8)
`ifdef STREAMING_FIFO_PEAK_EN
      , .peak_count(peak8), .peak_clr(clr8)
`endif
   );

   streaming_fifo_param #(.WIDTH(16), .DEPTH(5)) dut5 (
      .ap_clk(clk), .ap_rst(rst), .in0_V_V(in5), .out_V_V(out5),
      .count(cnt5), .almost_full(af5), .almost_empty(ae5)
`ifdef STREAMING_FIFO_PEAK_EN
      , .peak_count(peak5), .peak_clr(clr5)
`endif
   );

   logic [7:0]  exp8 [$];
   logic [15:0] exp5 [$];
   int unsigned rcv5 = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Monitor: checks each popped beat against the scoreboard, then records accepted pushes.
   always @(negedge clk) begin
      if (!rst) begin
         if (out8.TVALID && out8.TREADY) begin
            if (exp8.size() == 0) chk("sb8_unexpected_beat", 32'(out8.TDATA), 32'hFFFF_FFFF);
            else                  chk("sb8_data", 32'(out8.TDATA), 32'(exp8.pop_front()));
         end
         if (in8.TVALID && in8.TREADY) exp8.push_back(in8.TDATA);
         if (out5.TVALID && out5.TREADY) begin
            rcv5++;
            if (exp5.size() == 0) chk("sb5_unexpected_beat", 32'(out5.TDATA), 32'hFFFF_FFFF);
            else                  chk("sb5_data", 32'(out5.TDATA), 32'(exp5.pop_front()));
         end
         if (in5.TVALID && in5.TREADY) exp5.push_back(in5.TDATA);
         chk("cnt8_le_depth", 32'(cnt8 <= 4'd8), 32'd1);
         chk("cnt5_le_depth", 32'(cnt5 <= 3'd5), 32'd1);
      end
   end

   initial begin
      int unsigned k;
      int unsigned sent;
      logic        acc;

      in8.TVALID = 1'b0; in8.TDATA = '0; out8.TREADY = 1'b0;
      in5.TVALID = 1'b0; in5.TDATA = '0; out5.TREADY = 1'b0;
      rst = 1'b1;
      tick; tick;
      rst = 1'b0;
      tick;

      // Reset state
      chk("rst_tready",  32'(in8.TREADY),  32'd1);
      chk("rst_tvalid",  32'(out8.TVALID), 32'd0);
      chk("rst_count",   32'(cnt8),        32'd0);
      chk("rst_af",      32'(af8),         32'd0);
      chk("rst_ae",      32'(ae8),         32'd1);
      chk("rst_tdata",   32'(out8.TDATA),  32'd0);

      // Basic: downstream always ready, 0x01..0x05 back-to-back
      out8.TREADY = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         in8.TVALID = 1'b1;
         in8.TDATA  = 8'(i);
         tick;
         chk("basic_tvalid", 32'(out8.TVALID), 32'd1);
         chk("basic_tdata",  32'(out8.TDATA),  32'(i));
         chk("basic_count",  32'(cnt8),        32'd1);
      end
      in8.TVALID = 1'b0;
      tick;
      chk("basic_drained_count",  32'(cnt8),        32'd0);
      chk("basic_drained_tvalid", 32'(out8.TVALID), 32'd0);

      // Fill: 10 beats offered, downstream stalled
      out8.TREADY = 1'b0;
      k = 0;
      for (int j = 1; j <= 10; j++) begin
         in8.TVALID = 1'b1;
         in8.TDATA  = 8'(k);
         tick;
         k = (j < 8) ? j : 8;
         chk("fill_count",  32'(cnt8),        32'(k));
         chk("fill_tready", 32'(in8.TREADY),  32'(k < 8));
         chk("fill_af",     32'(af8),         32'(k >= 6));
         chk("fill_ae",     32'(ae8),         32'(k <= 2));
         chk("fill_tvalid", 32'(out8.TVALID), 32'd1);
         chk("fill_head",   32'(out8.TDATA),  32'h00);
      end

      // Full with one pop: ready returns the next cycle, one more beat fits
      in8.TDATA   = 8'h08;
      out8.TREADY = 1'b1;
      tick;
      chk("full_pop_count",  32'(cnt8),       32'd7);
      chk("full_pop_tready", 32'(in8.TREADY), 32'd1);
      out8.TREADY = 1'b0;
      tick;
      chk("refill_count",  32'(cnt8),       32'd8);
      chk("refill_tready", 32'(in8.TREADY), 32'd0);
      chk("refill_head",   32'(out8.TDATA), 32'h01);
      in8.TVALID = 1'b0;

      out8.TREADY = 1'b1;
      for (int b = 0; b < 20 && cnt8 != 0; b++) tick;
      chk("drain_count",    32'(cnt8),        32'd0);
      chk("drain_sb_empty", 32'(exp8.size()), 32'd0);

      // Backpressure: output held 20 cycles, unpushed TDATA ignored
      out8.TREADY = 1'b0;
      in8.TVALID  = 1'b1;
      in8.TDATA   = 8'hA5;
      tick;
      in8.TVALID = 1'b0;
      in8.TDATA  = 8'h3C;
      for (int c = 0; c < 20; c++) begin
         chk("bp_tvalid", 32'(out8.TVALID), 32'd1);
         chk("bp_tdata",  32'(out8.TDATA),  32'hA5);
         tick;
      end
      chk("bp_count", 32'(cnt8), 32'd1);
      out8.TREADY = 1'b1;
      tick;
      chk("bp_release_count", 32'(cnt8), 32'd0);

      // Reset mid-stream with 4 beats held
      out8.TREADY = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in8.TVALID = 1'b1;
         in8.TDATA  = 8'(8'h10 + i);
         tick;
      end
      in8.TVALID = 1'b0;
      chk("mid_count", 32'(cnt8), 32'd4);
      #2;
      rst = 1'b1;
      exp8.delete();
      tick;
      chk("mid_rst_tvalid", 32'(out8.TVALID), 32'd0);
      chk("mid_rst_count",  32'(cnt8),        32'd0);
      chk("mid_rst_tready", 32'(in8.TREADY),  32'd1);
`ifdef STREAMING_FIFO_PEAK_EN
      chk("mid_rst_peak",   32'(peak8),       32'd0);
`endif
      rst = 1'b0;
      out8.TREADY = 1'b1;
      tick; tick;
      chk("post_rst_tvalid", 32'(out8.TVALID), 32'd0);

      // Refill to 6, drain to 2, then clear the peak monitor
      out8.TREADY = 1'b0;
      for (int i = 0; i < 6; i++) begin
         in8.TVALID = 1'b1;
         in8.TDATA  = 8'(8'h20 + i);
         tick;
      end
      in8.TVALID = 1'b0;
      chk("refill6_count", 32'(cnt8), 32'd6);
`ifdef STREAMING_FIFO_PEAK_EN
      chk("peak_after_fill", 32'(peak8), 32'd6);
`endif
      out8.TREADY = 1'b1;
      for (int i = 0; i < 4; i++) tick;
      out8.TREADY = 1'b0;
      chk("pop4_count", 32'(cnt8), 32'd2);
`ifdef STREAMING_FIFO_PEAK_EN
      chk("peak_hold", 32'(peak8), 32'd6);
      clr8 = 1'b1;
      tick;
      clr8 = 1'b0;
      chk("peak_clr", 32'(peak8), 32'd2);
`endif
      out8.TREADY = 1'b1;
      for (int b = 0; b < 20 && cnt8 != 0; b++) tick;
      out8.TREADY = 1'b0;
      chk("final_drain8", 32'(exp8.size()), 32'd0);

      // Wrap: DEPTH=5, 1000 incrementing beats with random handshakes
      sent = 0;
      for (int cyc = 0; cyc < 20000 && rcv5 < 1000; cyc++) begin
         in5.TVALID  = (sent < 1000) && ($urandom_range(0, 3) != 0);
         in5.TDATA   = 16'(sent);
         out5.TREADY = ($urandom_range(0, 3) != 0);
         acc = in5.TVALID && in5.TREADY;
         tick;
         if (acc) sent++;
      end
      in5.TVALID  = 1'b0;
      out5.TREADY = 1'b0;
      tick;
      chk("wrap_received", 32'(rcv5),        32'd1000);
      chk("wrap_sb_empty", 32'(exp5.size()), 32'd0);
      chk("wrap_count",    32'(cnt5),        32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
